rcv_fifo_block: RTL

//  Parametrised successor to the single-byte UART receiver.

---
 rtl/rcv_pkg.sv | 24 ++
 rtl/rx_fifo.sv | 74 +++++++
 rtl/rcv_fifo_block.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rcv_pkg.sv
// ----------------------------------------------------------------------------
// rcv_pkg
// Shared types and helpers for the buffered serial receiver.
//   rx_state_t : receiver FSM states (IDLE, START, DATA, PARITY, STOP)
//   BIT_CNT_W  : width of the bit-position counter
//   cnt_width  : width needed for a counter running 0 .. max_val-1
// ----------------------------------------------------------------------------
package rcv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int BIT_CNT_W = 5;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// ----------------------------------------------------------------------------
// rx_fifo
// Synchronous FIFO with show-ahead read. The head entry is presented on
// rdata whenever the FIFO is non-empty. rdata reads 0 when the FIFO is empty.
// A push and a pop in the same cycle are both accepted when the FIFO is full.
// A pop while empty is ignored.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (accepted if not full, or if popping this cycle)
//   pop      : remove head entry (ignored when empty)
//   wdata    : write data
//   rdata    : head entry (show-ahead), 0 when empty
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of stored entries, 0 .. DEPTH
// ----------------------------------------------------------------------------
module rx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push needs, so a full FIFO still accepts it.
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers define validity
    // and empty entries are masked on rdata, so reset only costs logic here.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/rcv_fifo_block.sv
// ----------------------------------------------------------------------------
// rcv_fifo_block
// Asynchronous serial receiver with a receive FIFO. A frame is a start bit,
// DATA_BITS data bits LSB-first, an optional parity bit and STOP_BITS stop
// bits. Error-free frames are queued. Framing, parity and overrun errors are
// flagged.
//   clk           : system clock, rising edge
//   rst           : synchronous, active-high reset
//   serial_in     : asynchronous serial line, idle high
//   data_read     : pop FIFO head, one pop per high cycle
//   rx_data       : FIFO head (show-ahead), 0 when empty
//   data_ready    : FIFO not empty
//   overrun_error : good frame dropped on a full FIFO (sticky until a pop)
//   framing_error : last completed frame had a stop bit sampled 0
//   parity_error  : last completed frame failed the parity check
//   fifo_count    : number of FIFO entries
// ----------------------------------------------------------------------------
module rcv_fifo_block
    import rcv_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    input  logic                          data_read,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          data_ready,
    output logic                          overrun_error,
    output logic                          framing_error,
    output logic                          parity_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int BAUD_W   = cnt_width(CLKS_PER_BIT);

    // Input synchroniser plus one extra stage for start-edge detection.
    logic sync1_q, sync2_q, prev_q;

    rx_state_t              state_q,   state_d;
    logic [BAUD_W-1:0]      baud_q,    baud_d;
    logic [BIT_CNT_W-1:0]   bit_q,     bit_d;
    logic [DATA_BITS-1:0]   shift_q,   shift_d;
    logic                   framing_q, framing_d;
    logic                   parity_q,  parity_d;
    logic                   overrun_q, overrun_d;
    logic                   done_q,    done_d;

    logic baud_tick;
    logic push_req;
    logic fifo_full;
    logic fifo_empty;

    assign baud_tick = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // ------------------------------------------------------------------
    // Receiver FSM: next state, bit timing, shifting and frame flags
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        framing_d = framing_q;
        parity_d  = parity_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = START;
                    baud_d  = '0;
                end
            end

            START: begin
                if (baud_q == BAUD_W'(HALF_BIT - 1)) begin
                    baud_d = '0;
                    if (sync2_q) begin
                        // Line back high at mid-start: glitch, flags untouched.
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_d     = '0;
                        framing_d = 1'b0;
                        parity_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_CNT_W'(1);
                    if (bit_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            PARITY: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = STOP;
                    if (sync2_q != (^shift_q ^ (PARITY_ODD != 0)))
                        parity_d = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            STOP: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (!sync2_q) framing_d = 1'b1;
                    if (bit_q == BIT_CNT_W'(STOP_BITS - 1)) begin
                        // Leave at mid-stop so the next start edge is not missed.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame commit: one cycle after the final stop sample, when the
    // error flags already include that sample.
    // ------------------------------------------------------------------
    assign push_req = done_q && !framing_q && !parity_q;

    always_comb begin
        overrun_d = overrun_q;
        // Full implies non-empty, so data_read here is always a real pop.
        if (data_read && !fifo_empty)
            overrun_d = 1'b0;
        else if (push_req && fifo_full)
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            framing_q <= 1'b0;
            parity_q  <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sync1_q   <= serial_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            framing_q <= framing_d;
            parity_q  <= parity_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (data_read),
        .wdata (shift_q),
        .rdata (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign data_ready    = !fifo_empty;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;
    assign parity_error  = parity_q;

endmodule
